spi_byte_engine: RTL
====================

// Module: spi_byte_engine
// PURPOSE
// Byte-wide SPI master behind the PIO write-strobe decoder's spi_ce page.
// A CPU write to the SPI page launches one 8-bit full-duplex transfer (MSB first, CPHA=0).
// A CPU read returns the last received byte.
// Accesses that arrive while a transfer is running stall the 68000 via wait_req, which feeds the DTACK wait-term OR.
// PARAMETERS
// DATA_W  8  shift width in bits; sets the bit count per transfer
// DIV_W   3  width of cfg_div; half-period = 2^cfg_div x8m cycles
// PORTS
// x8m        in   1       8 MHz system clock; only clock in the block
// sysrst_n   in   1       reset, synchronous, active-low
// spi_ce     in   1       SPI page select from PIO decode, already qualified by AS#
// rw_n       in   1       68000 R/W#: 1 = read, 0 = write
// wdata      in   DATA_W  CPU data bus (xdb) sampled on write accept
// rdata      out  DATA_W  last received byte, for the CPLD readback mux
// cfg_div    in   DIV_W   SCLK divider select, from overlay_reg[7:5]
// cfg_cpol   in   1       SCLK idle level, from overlay_reg[4]
// busy       out  1       transfer in progress; routed to status_flags[2]
// done       out  1       one-cycle pulse when a transfer completes
// wait_req   out  1       holds DTACK off while a CPU access must wait
// spi_sclk   out  1       serial clock
// spi_mosi   out  1       serial data out
// spi_miso   in   1       serial data in; the board synchronizes it to x8m
// BEHAVIOUR
// - Reset (sysrst_n=0 on a x8m rising edge): state=IDLE, busy=0, done=0, wait_req=0, rdata=0,
//   spi_sclk=cfg_cpol, spi_mosi=1, bit counter=0. Applies mid-transfer: the transfer is aborted and no done pulse is issued.
// - wr_req = spi_ce & ~rw_n; rd_req = spi_ce & rw_n.
// - Accept: wr_req is high, its registered copy was low (first cycle of the strobe), and state=IDLE.
//   - On accept: tx_sr<=wdata; latch cfg_div/cfg_cpol into div_q/cpol_q; cnt<=0; state->SETUP.
// - Write during busy: wait_req=1 combinationally while wr_req & (state!=IDLE). The strobe stays high.
//   The accept then fires in the first IDLE cycle; the edge detector is re-armed for a pending stalled write.
// - Read during busy: wait_req=1 while rd_req & (state!=IDLE). rdata is therefore always the completed byte.
// - Reads and writes in IDLE: wait_req=0, zero wait states.
// - Half-period timer: reloads to 2^div_q - 1 on each state entry; a state advances when the timer reaches 0.
//   cfg_div changes during a transfer have no effect.
// - FSM:
//   - IDLE: sclk=cpol_q, mosi=1.
//   - SETUP (1 half-period): mosi=tx_sr[MSB], sclk=cpol_q.
//   - LEAD (1 half-period): sclk=~cpol_q. On entry, rx_sr <= {rx_sr[DATA_W-2:0], spi_miso}.
//   - TRAIL (1 half-period): sclk=cpol_q; on entry tx_sr shifts left, mosi=new MSB, cnt++.
//     When cnt reaches DATA_W, go to DONE; otherwise go to LEAD.
//   - DONE (1 cycle): rdata<=rx_sr, done=1, then IDLE.
// - busy=1 in every state except IDLE.
//   Busy duration = (2*DATA_W+1)*2^div_q + 1 cycles, counted from the cycle after accept.
// - Exactly DATA_W leading and DATA_W trailing SCLK edges per transfer; no glitches; sclk is registered.
// - cnt width is clog2(DATA_W)+1, so it does not wrap at DATA_W.
// - A write accepted in the same cycle as done leaves DONE->IDLE first; the accept lands on the following cycle.
// - rw_n changes while spi_ce is low are ignored.
// TESTING
// - div=0, cpol=0, MISO looped to MOSI, write 0xA5 -> 8 SCLK rising edges, MOSI 1,0,1,0,0,1,0,1, rdata=0xA5, busy high 18 cycles, one done pulse.
// - div=3, cpol=1, MISO tied 0, write 0xFF -> SCLK idles high, half-period 8 cycles, busy 137 cycles, rdata=0x00.
// - Write 0x3C while busy with 0x11 (div=2) -> wait_req high until IDLE; second transfer starts the next cycle with no byte lost; rdata ends at the 0x3C loopback value.
// - Read during transfer -> wait_req high until DONE; rdata sampled after wait_req falls equals the new byte, not the old one.
// - Assert sysrst_n=0 for 1 cycle at bit 4 -> next cycle: IDLE, sclk=cpol, mosi=1, rdata=0, no done pulse; a fresh write then completes normally.
// - Change cfg_div from 0 to 6 mid-transfer -> remaining half-periods stay at 1 cycle; the next transfer uses 64-cycle half-periods.

Source files
------------

// File: rtl/spi_byte_engine.sv
`default_nettype none
// ==========================================================================
// spi_byte_engine : byte-wide CPHA=0 SPI master on the PIO SPI page; stalls
//                   the 68000 through wait_req while a transfer is running.
// Rev 1.0
// ==========================================================================
module spi_byte_engine #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 3
) (
  input  logic              x8m,
  input  logic              sysrst_n,
  input  logic              spi_ce,
  input  logic              rw_n,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_cpol,
  output logic              busy,
  output logic              done,
  output logic              wait_req,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int TMR_W = (1 << DIV_W) - 1;
  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LEAD  = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              wr_req_q, wr_req_d;

  logic wr_req;
  logic rd_req;
  logic idle;
  logic accept;
  logic tmr_zero;

  // Half-period minus one: 2^div - 1 cycles of countdown.
  function automatic logic [TMR_W-1:0] half_reload(input logic [DIV_W-1:0] div);
    logic [TMR_W:0] one_hot;
    one_hot = {{TMR_W{1'b0}}, 1'b1} << div;
    return one_hot[TMR_W-1:0] - TMR_ONE;
  endfunction

  assign wr_req   = spi_ce & ~rw_n;
  assign rd_req   = spi_ce & rw_n;
  assign idle     = (state_q == ST_IDLE);
  assign accept   = wr_req & ~wr_req_q & idle;
  assign tmr_zero = (tmr_q == '0);

  // The strobe copy only arms once a write is taken, so a stalled write
  // still looks like a fresh edge when the engine returns to IDLE.
  assign wr_req_d = wr_req & (wr_req_q | accept);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    rdata_d = rdata_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    if (!idle && !tmr_zero) begin
      tmr_d = tmr_q - TMR_ONE;
    end
    case (state_q)
      ST_IDLE: begin
        cpol_d = cfg_cpol;
        sclk_d = cfg_cpol;
        mosi_d = 1'b1;
        if (accept) begin
          state_d = ST_SETUP;
          tx_sr_d = wdata;
          div_d   = cfg_div;
          cnt_d   = '0;
          tmr_d   = half_reload(cfg_div);
          mosi_d  = wdata[DATA_W-1];
        end
      end
      ST_SETUP, ST_TRAIL: begin
        if (tmr_zero) begin
          if (state_q == ST_TRAIL && cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LEAD;
            tmr_d   = half_reload(div_q);
            sclk_d  = ~cpol_q;
            rx_sr_d = {rx_sr_q[DATA_W-2:0], spi_miso};
          end
        end
      end
      ST_LEAD: begin
        if (tmr_zero) begin
          state_d = ST_TRAIL;
          tmr_d   = half_reload(div_q);
          sclk_d  = cpol_q;
          tx_sr_d = {tx_sr_q[DATA_W-2:0], tx_sr_q[DATA_W-1]};
          mosi_d  = tx_sr_q[DATA_W-2];
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        rdata_d = rx_sr_q;
        mosi_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge x8m) begin
    if (!sysrst_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      cnt_q    <= '0;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
      rdata_q  <= '0;
      div_q    <= '0;
      cpol_q   <= cfg_cpol;
      sclk_q   <= cfg_cpol;
      mosi_q   <= 1'b1;
      wr_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
      rdata_q  <= rdata_d;
      div_q    <= div_d;
      cpol_q   <= cpol_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      wr_req_q <= wr_req_d;
    end
  end

  assign busy     = ~idle;
  assign done     = (state_q == ST_DONE);
  assign wait_req = (wr_req | rd_req) & ~idle;
  assign rdata    = rdata_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

endmodule
`default_nettype wire
